// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD 7-segment scan display.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam logic [1:0] SLOT_ONES = 2'd0;
  localparam logic [1:0] SLOT_TENS = 2'd1;
  localparam logic [1:0] SLOT_HUNS = 2'd2;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef struct packed {
    logic [3:0] huns;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_digits_t;

  // ONES -> TENS -> HUNS -> ONES
  function automatic logic [1:0] slot_next(input logic [1:0] s);
    case (s)
      SLOT_ONES: slot_next = SLOT_TENS;
      SLOT_TENS: slot_next = SLOT_HUNS;
      default:   slot_next = SLOT_ONES;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-decimal codes 10..15 show a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 3-digit 7-segment driver with leading-zero blanking.
// Outputs are registered from the current slot and hold regs (one cycle of latency).
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] huns,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic            LZ_EN    = (BLANK_LZ != 0);
  localparam logic            ACT_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]      SEG_IDLE = ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]      AN_IDLE  = ACT_LOW ? 3'b111 : 3'b000;

  bcd_digits_t      hold;
  logic [1:0]       slot;
  logic [DIV_W-1:0] div;

  // Index order matches the slot encoding: [0]=ones, [1]=tens, [2]=huns.
  logic [2:0][3:0] digit;
  logic [2:0][6:0] dec;
  logic [2:0]      blank;

  assign digit = {hold.huns, hold.tens, hold.ones};

  for (genvar g = 0; g < 3; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (digit[g]),
      .seg   (dec[g])
    );
  end

  // Codes 10..15 are nonzero, so a dash never blanks.
  assign blank[0] = 1'b0;
  assign blank[1] = LZ_EN && (hold.huns == 4'd0) && (hold.tens == 4'd0);
  assign blank[2] = LZ_EN && (hold.huns == 4'd0);

  logic [6:0] seg_hi;
  logic [2:0] an_hi;

  always_comb begin
    seg_hi = SEG_OFF;
    an_hi  = 3'b000;
    case (slot)
      SLOT_ONES: begin seg_hi = dec[0]; an_hi = 3'b001; end
      SLOT_TENS: begin seg_hi = dec[1]; an_hi = 3'b010; end
      SLOT_HUNS: begin seg_hi = dec[2]; an_hi = 3'b100; end
      default:   begin seg_hi = SEG_OFF; an_hi = 3'b000; end
    endcase
    if ((slot == SLOT_TENS && blank[1]) || (slot == SLOT_HUNS && blank[2])) begin
      seg_hi = SEG_OFF;
      an_hi  = 3'b000;
    end
  end

  // Scan timing: divider wraps at CLK_DIV-1 and advances the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      slot <= SLOT_ONES;
    end else if (div == DIV_LAST) begin
      div  <= '0;
      slot <= slot_next(slot);
    end else begin
      div  <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      hold <= '0;
    else if (load)
      hold <= '{huns: huns, tens: tens, ones: ones};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= SEG_IDLE;
      an    <= AN_IDLE;
      frame <= 1'b0;
    end else begin
      seg   <= ACT_LOW ? ~seg_hi : seg_hi;
      an    <= ACT_LOW ? ~an_hi  : an_hi;
      frame <= (slot == SLOT_ONES) && (div == '0);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench: stimulus pushes expected outputs computed from a
// cycle-count model of the scan; a monitor pops and compares each cycle.
module tb_bcd_seg_scan;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 3 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst, load;
  logic [3:0] huns, tens, ones;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame;

  always #5 clk = ~clk;

  bcd_seg_scan #(
    .CLK_DIV        (CLK_DIV),
    .BLANK_LZ       (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .huns  (huns),
    .tens  (tens),
    .ones  (ones),
    .seg   (seg),
    .an    (an),
    .frame (frame)
  );

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   ncyc  = 0;

  // Model: k = edges since reset release; slot = (k / CLK_DIV) % 3 (0 ones, 1 tens, 2 huns).
  int         k = 0;
  logic [3:0] mh = 4'd0, mt = 4'd0, mo = 4'd0;

  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] enc(input logic [3:0] d);
    if (d > 4'd9) return 7'h40;
    return seg_tbl[d];
  endfunction

  task automatic step(input logic r, input logic l,
                      input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    exp_t       e;
    int         s;
    logic [3:0] d;
    bit         bl;
    rst = r; load = l; huns = h; tens = t; ones = o;
    if (r) begin
      e.an = 3'b111; e.seg = 7'h7F; e.frame = 1'b0;
      k = 0; mh = 4'd0; mt = 4'd0; mo = 4'd0;
    end else begin
      s  = (k / CLK_DIV) % 3;
      d  = (s == 0) ? mo : (s == 1) ? mt : mh;
      bl = (s == 2 && mh == 0) || (s == 1 && mh == 0 && mt == 0);
      e.frame = ((k % PERIOD) == 0);
      if (bl) begin
        e.an = 3'b111; e.seg = 7'h7F;
      end else begin
        e.an  = ~(3'b001 << s);
        e.seg = ~enc(d);
      end
      k++;
      if (l) begin mh = h; mt = t; mo = o; end
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // Monitor: sample 1 time unit after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (an !== e.an || seg !== e.seg || frame !== e.frame) begin
          fails++;
          $display("FAIL scan cyc%0d an/seg/frame got %b/%h/%b want %b/%h/%b",
                   ncyc, an, seg, frame, e.an, e.seg, e.frame);
        end
        ncyc++;
      end
    end
  end

  initial begin
    // Reset held 3 cycles, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(6);
    // Normal scan 1,2,3.
    step(1'b0, 1'b1, 4'd1, 4'd2, 4'd3);
    idle(30);
    // Leading zeros blanked.
    step(1'b0, 1'b1, 4'd0, 4'd0, 4'd7);
    idle(26);
    // Inner zero, then a dash in huns un-blanks everything.
    step(1'b0, 1'b1, 4'd0, 4'd5, 4'd0);
    idle(15);
    step(1'b0, 1'b1, 4'hC, 4'd5, 4'd0);
    idle(15);
    // Load exactly on a slot-advance edge, several times.
    for (int j = 0; j < 4; j++) begin
      while ((k % CLK_DIV) != CLK_DIV - 1) idle(1);
      step(1'b0, 1'b1, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
    end
    // Back-to-back loads.
    for (int j = 0; j < 24; j++)
      step(1'b0, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
    // Reset during TENS slot with divider = 2.
    step(1'b0, 1'b1, 4'd9, 4'd8, 4'd7);
    while ((k % PERIOD) != CLK_DIV + 2) idle(1);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(14);
    // Randomized traffic with zero-biased digits and rare resets.
    for (int j = 0; j < 1500; j++) begin
      logic [3:0] h, t, o;
      h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      o = 4'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, h, t, o);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream of the binary-to-BCD converter; consumes its huns/tens/ones digits.
- Latches the digits on a load strobe and drives one shared 3-digit, 7-segment display.
- Display is time-multiplexed with a programmable refresh divider, leading-zero blanking and out-of-range (dash) indication.
- All outputs are registered.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot; legal range ≥1; 1 = advance slot every cycle.
- BLANK_LZ, 1, 1 = enable leading-zero blanking; 0 = always show all three digits.
- SEG_ACTIVE_LOW, 1, 1 = seg and an are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture huns/tens/ones at this rising edge.
- huns  in  4  BCD hundreds digit.
- tens  in  4  BCD tens digit.
- ones  in  4  BCD ones digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- an  out  3  digit enables {huns,tens,ones}, one-hot, polarity per SEG_ACTIVE_LOW.
- frame  out  1  one-cycle pulse marking the start of each full scan.

Behaviour:
- Reset values (active-low case):
  - hold regs = 0, slot = ONES, divider = 0.
  - an = 3'b111 (all off), seg = 7'h7F (all off), frame = 0.
  - Reset mid-slot or mid-frame aborts immediately, with no partial-slot completion.
- Divider: counts 0..CLK_DIV-1. At the edge where it equals CLK_DIV-1, it wraps to 0 and slot advances ONES → TENS → HUNS → ONES.
- Hold regs: when load=1 at an edge, huns/tens/ones are captured. A load on every cycle is legal (continuous update).
- Output registers: computed from current slot and current hold regs, giving one cycle of latency.
  - After rst deasserts, the first edge drives the ONES slot.
  - A load at edge N is visible on seg at edge N+1 if its slot is active.
  - If load and slot advance occur at the same edge, the next output uses both the new slot and the new data.
- Segment encoding (active-high form, inverted when SEG_ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any digit value 10..15 displays a dash = 40. This covers huns overflow from 12-bit inputs >999.
- Leading-zero blanking (BLANK_LZ=1):
  - huns blanks when huns==0.
  - tens blanks when huns==0 and tens==0.
  - ones never blanks.
  - Digits 10..15 count as nonzero.
  - A blanked slot drives an all-off and seg all-off for that slot's full duration; scan timing is unchanged.
- frame: high for exactly one cycle, in the same cycle the output registers first drive the ONES slot of a new scan. This includes the first cycle after reset.
- Scan period: 3*CLK_DIV cycles.

Decomposition:
- Package bcd_disp_pkg holds:
  - slot encoding constants SLOT_ONES=0, SLOT_TENS=1, SLOT_HUNS=2;
  - the active-high segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
- One natural sub-module, seg7_decode: combinational 4-bit digit → 7-bit active-high segments, with dash for 10..15. Polarity inversion stays in the top.

Test Plan (CLK_DIV=4, BLANK_LZ=1, SEG_ACTIVE_LOW=1):
1. Reset behaviour:
   - rst high 3 cycles → an=111, seg=7F, frame=0 throughout.
   - First cycle after release → frame=1, an=110, seg=40 (ones digit "0").
2. Normal scan:
   - load huns=1, tens=2, ones=3 → repeating sequence: an=110/seg=30, an=101/seg=24, an=011/seg=79.
   - Each slot lasts 4 cycles; frame pulses every 12 cycles.
3. Leading-zero blanking:
   - load 0,0,7 → HUNS and TENS slots show an=111, seg=7F; ONES slot shows an=110, seg=78.
   - Scan period stays 12 cycles.
4. Inner zero and dash:
   - load 0,5,0 → TENS slot seg=12, ONES slot seg=40, HUNS slot blanked.
   - Then load huns=4'hC → HUNS slot seg=3F (dash), tens and ones no longer blanked.
5. Load timing:
   - Assert load exactly at a slot-advance edge → the next cycle shows the new slot with the new data.
   - Back-to-back loads → seg tracks each value with 1-cycle latency.
6. Reset mid-operation:
   - rst during the TENS slot at divider=2 → next cycle an=111, seg=7F.
   - After release, ONES slot shows digit 0, frame=1, and a full 4 cycles elapse before TENS.
